lcd_8080_bus_ctrl: RTL
======================

Name: lcd_8080_bus_ctrl

Overview:
Avalon-MM slave that generates complete 8080-style LCD bus cycles (CS_n, RS, WR_n, RD_n, data bus) in hardware. It replaces per-pin PIO bit-banging of the LCD control strobes. Software writes one register per LCD transaction; the block sequences the setup, strobe and hold phases and captures read data. It sits between the Nios II Avalon fabric and the LCD connector pins.

Parameters:
DATA_W, 16, LCD data bus width (8 or 16)
SETUP_DEF, 1, reset value of TIMING.setup field
STROBE_DEF, 2, reset value of TIMING.strobe field
HOLD_DEF, 1, reset value of TIMING.hold field

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
read_n  in  1  Avalon read strobe, active low (readdata is combinational; read_n has no side effects)
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, zero-latency mux
lcd_cs_n  out  1  LCD chip select
lcd_rs  out  1  register select (0 = command, 1 = data)
lcd_wr_n  out  1  write strobe
lcd_rd_n  out  1  read strobe
lcd_db_out  out  DATA_W  data driven to the pad
lcd_db_oe  out  1  pad output enable
lcd_db_in  in  DATA_W  data from the pad, pre-synchronised at the pad ring
lcd_rst_n  out  1  LCD panel reset

Behaviour:
- Reset (async, reset_n=0, including mid-cycle): FSM returns to IDLE.
  - Outputs: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_db_out=0, lcd_db_oe=0, lcd_rst_n=0.
  - Registers: rdata=0, busy=0, overrun=0, TIMING=defaults.
- All LCD outputs are registered; there is no combinational path from Avalon inputs to the pins.
- Register map. A write is accepted when chipselect=1 and write_n=0.
  - 0 CMD: write starts a write cycle with RS=0 and data=writedata[DATA_W-1:0]. Read returns rdata, zero-extended.
  - 1 DATA: write starts a write cycle with RS=1. Read returns rdata.
  - 2 CTRL: write bit0=1 starts a read cycle with RS=writedata[1]; bit2=1 clears overrun. Read returns {30'b0, overrun, busy}.
  - 3 TIMING: [3:0] setup, [7:4] strobe, [11:8] hold, [16] lcd_rst_n value. Read returns the stored fields; other bits read 0.
- A TIMING write while busy takes effect from the next transaction. The running cycle uses the values latched at its start.
- Start while busy: the request is ignored and overrun is set (sticky). On a CTRL write with both bit0 and bit2 set while busy, the clear wins and overrun ends at 0.
- FSM states: IDLE, SETUP, STROBE, HOLD. Each phase lasts field+1 clocks, so a field value of 0 gives 1 clock.
  - IDLE: on an accepted start, latch rs, dir and data plus the three timing fields. Load the phase counter. Go to SETUP on the next edge and set busy=1 on the same edge.
  - SETUP: cs_n=0, rs valid. oe=1 and db_out=data for a write; oe=0 for a read. Counter reaches 0 -> STROBE.
  - STROBE: wr_n=0 for a write, rd_n=0 for a read. For a read, rdata is sampled from lcd_db_in on the edge that ends the last STROBE clock. Counter reaches 0 -> HOLD.
  - HOLD: strobes high. cs_n, rs, oe and db_out unchanged. Counter reaches 0 -> IDLE, with busy=0 and cs_n=1 on the same edge. oe drops for a write; db_out keeps its last value.
- Total bus cycle = setup+strobe+hold+3 clocks. busy is 1 for exactly that many clocks.
- A new start is accepted in the first IDLE cycle after busy falls (back-to-back, no gap cycle required).

Decomposition:
- Package lcd_bus_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD)
  - register address constants (CMD=0, DATA=1, CTRL=2, TIMING=3)
  - TIMING and CTRL bit-position constants
  - field width constant TW=4
- One sub-module, lcd_phase_timer: a TW-bit loadable down-counter with load, value and done outputs, reused across all three phases.

Test Plan:
- Reset, then read TIMING -> 0x00000121. Read CTRL -> 0. lcd_cs_n/wr_n/rd_n=1, lcd_rst_n=0.
- Write TIMING=0x00010121, then CMD=0x2C with defaults -> lcd_rst_n=1.
  - cs_n low for 7 clocks, rs=0, wr_n low on clocks 3-5, db_out=0x002C, oe high for 7 clocks.
  - busy reads 1 throughout and 0 afterwards.
- Drive lcd_db_in=0xA5C3, write CTRL=0x3 -> rd_n low for 3 clocks, rs=1, oe=0. Afterwards a CMD-address read returns 0x0000A5C3.
- Write DATA=0x1234, then DATA=0x5678 two clocks later -> second write ignored, CTRL reads 0x3 while busy and 0x2 after. Write CTRL=0x4 -> CTRL reads 0.
- Write TIMING=0x00010000, then DATA=0xFFFF -> 3-clock cycle: SETUP 1, STROBE 1, HOLD 1.
  - Immediately write DATA=0x0001 on the first IDLE cycle -> accepted, no overrun.
- Assert reset_n=0 during STROBE of a write -> outputs return to their reset values that cycle. TIMING reads 0x121 after release.

Source files
------------

// File: rtl/lcd_8080_bus_ctrl_pkg.sv
// Shared types and constants for the 8080-style LCD bus controller.
package lcd_bus_pkg;

  // Width of each timing field and of the phase counter.
  localparam int unsigned TW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } lcd_state_e;

  // Register addresses.
  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  // TIMING register layout.
  localparam int unsigned TIM_SETUP_LSB  = 0;
  localparam int unsigned TIM_STROBE_LSB = 4;
  localparam int unsigned TIM_HOLD_LSB   = 8;
  localparam int unsigned TIM_RST_BIT    = 16;

  // CTRL write bits.
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_RS_BIT    = 1;
  localparam int unsigned CTRL_CLR_BIT   = 2;

  // CTRL read bits.
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_OVR_BIT   = 1;

endpackage

// File: rtl/lcd_8080_bus_ctrl_if.sv
// Avalon-MM register port of the LCD bus controller.
interface lcd_8080_bus_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/lcd_8080_bus_ctrl_phase_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
module lcd_phase_timer
  import lcd_bus_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/lcd_8080_bus_ctrl.sv
// Avalon-MM slave sequencing complete 8080-style LCD write/read bus cycles.
module lcd_8080_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SETUP_DEF  = 1,
  parameter int unsigned STROBE_DEF = 2,
  parameter int unsigned HOLD_DEF   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lcd_8080_bus_ctrl_if.slave   avs,
  output logic                 lcd_cs_n,
  output logic                 lcd_rs,
  output logic                 lcd_wr_n,
  output logic                 lcd_rd_n,
  output logic [DATA_W-1:0]    lcd_db_out,
  output logic                 lcd_db_oe,
  input  logic [DATA_W-1:0]    lcd_db_in,
  output logic                 lcd_rst_n
);

  lcd_state_e state_q, state_d;

  logic [TW-1:0] tim_setup_q, tim_setup_d;
  logic [TW-1:0] tim_strobe_q, tim_strobe_d;
  logic [TW-1:0] tim_hold_q, tim_hold_d;
  logic          tim_rst_q, tim_rst_d;

  logic [TW-1:0] cur_strobe_q, cur_strobe_d;
  logic [TW-1:0] cur_hold_q, cur_hold_d;
  logic          dir_q, dir_d;          // 1 = read cycle
  logic          rs_q, rs_d;
  logic [DATA_W-1:0] db_out_q, db_out_d;
  logic          oe_q, oe_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic          rd_n_q, rd_n_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic          overrun_q, overrun_d;

  logic          wr_acc;
  logic          start_req;
  logic          busy;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic [TW-1:0] tmr_value_unused;
  logic          unused_bits;

  assign wr_acc    = avs.chipselect & ~avs.write_n;
  assign start_req = wr_acc & ((avs.address == ADDR_CMD) || (avs.address == ADDR_DATA) ||
                     ((avs.address == ADDR_CTRL) && avs.writedata[CTRL_START_BIT]));
  assign busy      = (state_q != ST_IDLE);
  assign unused_bits = ^{avs.read_n, avs.writedata};

  lcd_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value_unused),
    .done     (tmr_done)
  );

  // Software-visible TIMING fields and the sticky overrun flag.
  always_comb begin
    tim_setup_d  = tim_setup_q;
    tim_strobe_d = tim_strobe_q;
    tim_hold_d   = tim_hold_q;
    tim_rst_d    = tim_rst_q;
    overrun_d    = overrun_q;
    if (wr_acc && (avs.address == ADDR_TIMING)) begin
      tim_setup_d  = avs.writedata[TIM_SETUP_LSB  +: TW];
      tim_strobe_d = avs.writedata[TIM_STROBE_LSB +: TW];
      tim_hold_d   = avs.writedata[TIM_HOLD_LSB   +: TW];
      tim_rst_d    = avs.writedata[TIM_RST_BIT];
    end
    if (start_req && busy) overrun_d = 1'b1;
    // Clear is applied last so it beats a simultaneous rejected start.
    if (wr_acc && (avs.address == ADDR_CTRL) && avs.writedata[CTRL_CLR_BIT]) overrun_d = 1'b0;
  end

  // Phase sequencing; transaction parameters are latched at the start.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    cur_strobe_d = cur_strobe_q;
    cur_hold_d   = cur_hold_q;
    dir_d        = dir_q;
    rs_d         = rs_q;
    db_out_d     = db_out_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_val      = tim_setup_q;
          cur_strobe_d = tim_strobe_q;
          cur_hold_d   = tim_hold_q;
          dir_d        = (avs.address == ADDR_CTRL);
          if (avs.address == ADDR_CTRL) begin
            rs_d = avs.writedata[CTRL_RS_BIT];
          end else begin
            rs_d     = (avs.address == ADDR_DATA);
            db_out_d = avs.writedata[DATA_W-1:0];
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = cur_strobe_q;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = cur_hold_q;
          if (dir_q) rdata_d = lcd_db_in;
        end
      end
      ST_HOLD: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the flops track the state register.
  always_comb begin
    cs_n_d = (state_d == ST_IDLE);
    oe_d   = (state_d != ST_IDLE) && !dir_d;
    wr_n_d = !((state_d == ST_STROBE) && !dir_d);
    rd_n_d = !((state_d == ST_STROBE) && dir_d);
  end

  // State, registers and registered pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tim_setup_q  <= TW'(SETUP_DEF);
      tim_strobe_q <= TW'(STROBE_DEF);
      tim_hold_q   <= TW'(HOLD_DEF);
      tim_rst_q    <= 1'b0;
      overrun_q    <= 1'b0;
      cur_strobe_q <= '0;
      cur_hold_q   <= '0;
      dir_q        <= 1'b0;
      rs_q         <= 1'b0;
      db_out_q     <= '0;
      rdata_q      <= '0;
      oe_q         <= 1'b0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      tim_setup_q  <= tim_setup_d;
      tim_strobe_q <= tim_strobe_d;
      tim_hold_q   <= tim_hold_d;
      tim_rst_q    <= tim_rst_d;
      overrun_q    <= overrun_d;
      cur_strobe_q <= cur_strobe_d;
      cur_hold_q   <= cur_hold_d;
      dir_q        <= dir_d;
      rs_q         <= rs_d;
      db_out_q     <= db_out_d;
      rdata_q      <= rdata_d;
      oe_q         <= oe_d;
      cs_n_q       <= cs_n_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      ADDR_CMD, ADDR_DATA: avs.readdata = 32'(rdata_q);
      ADDR_CTRL: begin
        avs.readdata[STAT_BUSY_BIT] = busy;
        avs.readdata[STAT_OVR_BIT]  = overrun_q;
      end
      ADDR_TIMING: begin
        avs.readdata[TIM_SETUP_LSB  +: TW] = tim_setup_q;
        avs.readdata[TIM_STROBE_LSB +: TW] = tim_strobe_q;
        avs.readdata[TIM_HOLD_LSB   +: TW] = tim_hold_q;
        avs.readdata[TIM_RST_BIT]          = tim_rst_q;
      end
      default: avs.readdata = '0;
    endcase
  end

  assign lcd_cs_n   = cs_n_q;
  assign lcd_rs     = rs_q;
  assign lcd_wr_n   = wr_n_q;
  assign lcd_rd_n   = rd_n_q;
  assign lcd_db_out = db_out_q;
  assign lcd_db_oe  = oe_q;
  assign lcd_rst_n  = tim_rst_q;

endmodule
